mem_access_unit: RTL and testbench

- Multi-cycle memory sequencer between the CPU core and the PicoRV32 native memory interface.
- Serves both instruction fetches and data loads/stores of byte, half, word (and dword when DATA_W=64).
- Performs byte-lane steering, write-strobe generation, load sign/zero extension, misalignment rejection and a bus-timeout fault.
- Lets the core FSM issue one request and wait for one response, instead of driving the bus directly.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit: access sizes,
// sequencer states and byte-lane arithmetic.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_BUS  = 2'd1,
    MAU_ERR  = 2'd2
  } mau_state_t;

  localparam int BYTE_W    = 8;
  localparam int MAX_LANES = 8;

  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic int size_bytes(input mem_size_t s);
    return 1 << int'(s);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication and strobes on the way
// out, load extraction and sign/zero extension on the way back.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_size_t                   i_st_size,
  input  logic [$clog2(DATA_W/8)-1:0] i_st_off,
  input  logic                        i_st_we,
  input  logic [DATA_W-1:0]           i_st_wdata,
  output logic [DATA_W-1:0]           o_st_wdata,
  output logic [DATA_W/8-1:0]         o_st_wstrb,
  input  mem_size_t                   i_ld_size,
  input  logic [$clog2(DATA_W/8)-1:0] i_ld_off,
  input  logic                        i_ld_unsigned,
  input  logic [DATA_W-1:0]           i_ld_rdata,
  output logic [DATA_W-1:0]           o_ld_rdata
);

  localparam int LANES = lane_count(DATA_W);

  logic [DATA_W-1:0] w_ld_shift;
  logic              w_ld_sign;
  int                w_st_bytes;
  int                w_ld_bytes;

  assign w_ld_shift = i_ld_rdata >> {i_ld_off, 3'b000};

  // Each lane takes the chunk byte it lines up with, so every aligned slot
  // of the bus carries a full copy of the store data.
  always_comb begin
    w_st_bytes = size_bytes(i_st_size);
    o_st_wdata = '0;
    o_st_wstrb = '0;
    for (int i = 0; i < LANES; i++) begin
      o_st_wdata[8*i +: 8] = i_st_wdata[8*(i & (w_st_bytes - 1)) +: 8];
      o_st_wstrb[i] = i_st_we && (i >= int'(i_st_off)) &&
                      (i < int'(i_st_off) + w_st_bytes);
    end
  end

  always_comb begin
    w_ld_bytes = size_bytes(i_ld_size);
    case (i_ld_size)
      MEM_B:   w_ld_sign = w_ld_shift[7];
      MEM_H:   w_ld_sign = w_ld_shift[15];
      MEM_W:   w_ld_sign = w_ld_shift[31];
      default: w_ld_sign = w_ld_shift[DATA_W-1];
    endcase
    o_ld_rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      o_ld_rdata[8*i +: 8] = (i < w_ld_bytes) ? w_ld_shift[8*i +: 8]
                                              : {8{w_ld_sign && !i_ld_unsigned}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences one core request onto the PicoRV32 native bus and returns a
// single registered response pulse; a bus that never answers latches a fault.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 16,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_instr,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                fault,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LANES = lane_count(DATA_W);
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mau_state_t        r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  mem_size_t         r_size, w_size;
  logic [OFF_W-1:0]  r_off, w_off;
  logic              r_unsigned, w_unsigned;
  logic              r_we, w_we;

  logic              r_req_ready, w_req_ready;
  logic              r_rsp_valid, w_rsp_valid;
  logic              r_rsp_err, w_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              r_fault, w_fault;
  logic              r_mem_valid, w_mem_valid;
  logic              r_mem_instr, w_mem_instr;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic [LANES-1:0]  r_mem_wstrb, w_mem_wstrb;

  mem_size_t         w_req_size;
  logic              w_misalign;
  logic              w_illegal;
  logic [OFF_W-1:0]  w_req_off;
  logic [DATA_W-1:0] w_st_wdata;
  logic [LANES-1:0]  w_st_wstrb;
  logic [DATA_W-1:0] w_ld_rdata;

  assign w_req_size = mem_size_t'(req_size);

  always_comb begin
    case (req_size)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = req_addr[0];
      2'd2:    w_misalign = |req_addr[1:0];
      default: w_misalign = |req_addr[2:0];
    endcase
  end

  assign w_illegal = ((CHECK_ALIGN != 0) && w_misalign) ||
                     ((req_size == 2'd3) && (DATA_W < 64));
  // Dropping the sub-size offset bits is what makes CHECK_ALIGN=0 truncate.
  assign w_req_off = req_addr[OFF_W-1:0] &
                     ~OFF_W'((32'd1 << req_size) - 32'd1);

  mem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane_align (
    .i_st_size     (w_req_size),
    .i_st_off      (w_req_off),
    .i_st_we       (req_we),
    .i_st_wdata    (req_wdata),
    .o_st_wdata    (w_st_wdata),
    .o_st_wstrb    (w_st_wstrb),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (mem_rdata),
    .o_ld_rdata    (w_ld_rdata)
  );

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_size      = r_size;
    w_off       = r_off;
    w_unsigned  = r_unsigned;
    w_we        = r_we;
    w_mem_valid = r_mem_valid;
    w_mem_instr = r_mem_instr;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_mem_wstrb = r_mem_wstrb;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    w_fault     = r_fault;
    case (r_state)
      MAU_IDLE: begin
        if (req_valid && r_req_ready) begin
          if (w_illegal) begin
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
          end else begin
            w_state     = MAU_BUS;
            w_cnt       = '0;
            w_size      = w_req_size;
            w_off       = w_req_off;
            w_unsigned  = req_unsigned;
            w_we        = req_we;
            w_mem_valid = 1'b1;
            w_mem_instr = req_instr;
            w_mem_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            w_mem_wdata = w_st_wdata;
            w_mem_wstrb = w_st_wstrb;
          end
        end
      end
      MAU_BUS: begin
        if (mem_ready && r_mem_valid) begin
          w_state     = MAU_IDLE;
          w_mem_valid = 1'b0;
          w_mem_instr = 1'b0;
          w_mem_wstrb = '0;
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_we ? '0 : w_ld_rdata;
        end else if ((TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
          w_state     = MAU_ERR;
          w_mem_valid = 1'b0;
          w_mem_instr = 1'b0;
          w_mem_wstrb = '0;
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_fault     = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      MAU_ERR: begin
        w_mem_valid = 1'b0;
        w_fault     = 1'b1;
      end
      default: w_state = MAU_IDLE;
    endcase
    w_req_ready = (w_state == MAU_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= MAU_IDLE;
      r_cnt       <= '0;
      r_size      <= MEM_B;
      r_off       <= '0;
      r_unsigned  <= 1'b0;
      r_we        <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_fault     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_instr <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_size      <= w_size;
      r_off       <= w_off;
      r_unsigned  <= w_unsigned;
      r_we        <= w_we;
      r_req_ready <= w_req_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
      r_fault     <= w_fault;
      r_mem_valid <= w_mem_valid;
      r_mem_instr <= w_mem_instr;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_mem_wstrb <= w_mem_wstrb;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign fault     = r_fault;
  assign mem_valid = r_mem_valid;
  assign mem_instr = r_mem_instr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a byte-arithmetic model
// of loads, stores, alignment rules and the bus timeout.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_instr = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        fault;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        mv1;
    logic        mi1;
    logic [31:0] ma1;
    logic [31:0] mw1;
    logic [3:0]  ms1;
    bit          stable;
    int          rsp_cycle;
    logic        err;
    logic        flt;
    logic        rdy;
    logic        mv;
    logic        mi;
    logic [3:0]  ms;
    logic [31:0] rdata;
  } obs_t;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .CHECK_ALIGN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .fault(fault),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Reference model: plain byte arithmetic on a 4-byte bus.
  function automatic bit m_legal(input int size, input logic [31:0] addr);
    if (size == 3) return 1'b0;
    return (addr % (32'd1 << size)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input int size, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] rd);
    int nb = 1 << size;
    logic [31:0] raw = rd >> (8 * (addr % 4));
    logic [31:0] mask;
    if (nb == 4) return raw;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    raw = raw & mask;
    if (!uns && raw[8*nb-1]) raw = raw | ~mask;
    return raw;
  endfunction

  function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
    if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [3:0] m_wstrb(input int size, input bit we, input logic [31:0] addr);
    int nb = 1 << size;
    if (!we) return 4'b0000;
    return 4'(((1 << nb) - 1) << (addr % 4));
  endfunction

  // Presents one request and observes the bus and response; mem_ready is
  // raised after `delay` waiting cycles of mem_valid.
  task automatic drive_txn(input bit instr, input bit we, input logic [1:0] size,
                           input bit uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay, output obs_t o);
    req_instr = instr; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
    mem_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    o.mv1 = mem_valid; o.mi1 = mem_instr; o.ma1 = mem_addr;
    o.mw1 = mem_wdata; o.ms1 = mem_wstrb; o.stable = 1'b1;
    o.rsp_cycle = -1; o.err = 1'b0; o.flt = 1'b0; o.rdy = 1'b0;
    o.mv = 1'b0; o.mi = 1'b0; o.ms = '0; o.rdata = '0;
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      mem_ready = 1'b0;
      if (rsp_valid === 1'b1) begin
        o.rsp_cycle = n; o.err = rsp_err; o.flt = fault; o.rdy = req_ready;
        o.mv = mem_valid; o.mi = mem_instr; o.ms = mem_wstrb; o.rdata = rsp_rdata;
        break;
      end
      if (mem_valid !== o.mv1 || mem_instr !== o.mi1 || mem_addr !== o.ma1 ||
          mem_wdata !== o.mw1 || mem_wstrb !== o.ms1) o.stable = 1'b0;
      if (n - 1 == delay) mem_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset.req_ready: got %b expected 0", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, fault, mem_valid, mem_instr} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset.flags: got %b expected 00000", {rsp_valid, rsp_err, fault, mem_valid, mem_instr});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL reset.data: got %h %h %h %h expected zeros", mem_addr, mem_wdata, mem_wstrb, rsp_rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset.ready_after: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_load();
    obs_t o;
    drive_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0, o);
    checks++;
    if (o.mv1 !== 1'b1 || o.ma1 !== 32'h104 || o.ms1 !== 4'b0000) begin
      errors++; $display("[TB] FAIL word_load.bus: got v=%b a=%h s=%b expected v=1 a=104 s=0000", o.mv1, o.ma1, o.ms1);
    end
    checks++;
    if (o.rsp_cycle != 2) begin errors++; $display("[TB] FAIL word_load.latency: got %0d expected 2", o.rsp_cycle); end
    checks++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
      errors++; $display("[TB] FAIL word_load.rsp: got %h err=%b expected deadbeef err=0", o.rdata, o.err);
    end
    checks++;
    if (o.mv !== 1'b0 || o.rdy !== 1'b1) begin
      errors++; $display("[TB] FAIL word_load.after: got mv=%b rdy=%b expected mv=0 rdy=1", o.mv, o.rdy);
    end
  endtask

  task automatic test_byte_load();
    obs_t o;
    for (int u = 0; u < 2; u++) begin
      drive_txn(1'b0, 1'b0, 2'd0, u[0], 32'h103, 32'h0, 32'h80FF_FF7F, 1, o);
      checks++;
      if (o.rdata !== m_load(0, u[0], 32'h103, 32'h80FF_FF7F) || o.rsp_cycle != 3) begin
        errors++; $display("[TB] FAIL byte_load.uns%0d: got %h at %0d expected %h at 3",
                           u, o.rdata, o.rsp_cycle, m_load(0, u[0], 32'h103, 32'h80FF_FF7F));
      end
    end
  endtask

  task automatic test_half_store();
    obs_t o;
    drive_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'hABCD_1234, 32'h5555_AAAA, 3, o);
    checks++;
    if (o.ma1 !== 32'h200 || o.mw1 !== 32'h1234_1234 || o.ms1 !== 4'b1100) begin
      errors++; $display("[TB] FAIL half_store.bus: got a=%h d=%h s=%b expected a=200 d=12341234 s=1100", o.ma1, o.mw1, o.ms1);
    end
    checks++;
    if (o.stable !== 1'b1) begin errors++; $display("[TB] FAIL half_store.stable: got %b expected 1", o.stable); end
    checks++;
    if (o.rsp_cycle != 5 || o.rdata !== 32'h0 || o.err !== 1'b0) begin
      errors++; $display("[TB] FAIL half_store.rsp: got cyc=%0d d=%h e=%b expected cyc=5 d=0 e=0", o.rsp_cycle, o.rdata, o.err);
    end
    checks++;
    if (o.ms !== 4'b0000 || o.mv !== 1'b0) begin
      errors++; $display("[TB] FAIL half_store.release: got s=%b v=%b expected s=0000 v=0", o.ms, o.mv);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    logic [31:0] addrs [3] = '{32'h105, 32'h301, 32'h0};
    logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd3};
    for (int k = 0; k < 3; k++) begin
      drive_txn(1'b0, 1'b0, sizes[k], 1'b0, addrs[k], 32'h0, 32'h1111_2222, 0, o);
      checks++;
      if (o.rsp_cycle != 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
        errors++; $display("[TB] FAIL misaligned%0d.rsp: got cyc=%0d e=%b d=%h expected cyc=1 e=1 d=0", k, o.rsp_cycle, o.err, o.rdata);
      end
      checks++;
      if (o.mv1 !== 1'b0 || o.mv !== 1'b0 || o.rdy !== 1'b1) begin
        errors++; $display("[TB] FAIL misaligned%0d.bus: got v=%b/%b rdy=%b expected v=0/0 rdy=1", k, o.mv1, o.mv, o.rdy);
      end
    end
    drive_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h108, 32'h0, 32'h0BAD_F00D, 1, o);
    checks++;
    if (o.rsp_cycle != 3 || o.rdata !== 32'h0BAD_F00D || o.err !== 1'b0) begin
      errors++; $display("[TB] FAIL misaligned.follow: got cyc=%0d d=%h e=%b expected cyc=3 d=0badf00d e=0", o.rsp_cycle, o.rdata, o.err);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd = $urandom;
      bit          we = 1'($urandom_range(0, 1));
      bit          uns = 1'($urandom_range(0, 1));
      bit          ins = 1'($urandom_range(0, 1));
      int          dly = $urandom_range(0, TO - 1);
      bit          legal;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      legal = m_legal(int'(size), addr);
      drive_txn(ins, we, size, uns, addr, wd, rd, dly, o);
      checks++;
      if (o.rsp_cycle != (legal ? dly + 2 : 1) || o.err !== !legal) begin
        errors++; $display("[TB] FAIL b2b%0d.rsp: got cyc=%0d e=%b expected cyc=%0d e=%b",
                           t, o.rsp_cycle, o.err, legal ? dly + 2 : 1, !legal);
      end
      checks++;
      if (o.rdata !== ((legal && !we) ? m_load(int'(size), uns, addr, rd) : 32'h0)) begin
        errors++; $display("[TB] FAIL b2b%0d.rdata: got %h expected %h", t, o.rdata,
                           (legal && !we) ? m_load(int'(size), uns, addr, rd) : 32'h0);
      end
      if (legal) begin
        checks++;
        if (o.mv1 !== 1'b1 || o.mi1 !== ins || o.ma1 !== (addr & ~32'h3) ||
            o.ms1 !== m_wstrb(int'(size), we, addr) || !o.stable) begin
          errors++; $display("[TB] FAIL b2b%0d.bus: got v=%b i=%b a=%h s=%b st=%b expected v=1 i=%b a=%h s=%b st=1",
                             t, o.mv1, o.mi1, o.ma1, o.ms1, o.stable, ins, addr & ~32'h3, m_wstrb(int'(size), we, addr));
        end
        if (we) begin
          checks++;
          if (o.mw1 !== m_wdata(int'(size), wd)) begin
            errors++; $display("[TB] FAIL b2b%0d.wdata: got %h expected %h", t, o.mw1, m_wdata(int'(size), wd));
          end
        end
      end else begin
        checks++;
        if (o.mv1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b%0d.nobus: got %b expected 0", t, o.mv1); end
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 1000, o);
    checks++;
    if (o.rsp_cycle != TO + 1 || o.err !== 1'b1 || o.flt !== 1'b1 || o.rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL timeout.rsp: got cyc=%0d e=%b f=%b d=%h expected cyc=%0d e=1 f=1 d=0",
                         o.rsp_cycle, o.err, o.flt, o.rdata, TO + 1);
    end
    checks++;
    if (o.mv !== 1'b0 || o.rdy !== 1'b0 || !o.stable) begin
      errors++; $display("[TB] FAIL timeout.bus: got v=%b rdy=%b st=%b expected v=0 rdy=0 st=1", o.mv, o.rdy, o.stable);
    end
    req_addr = 32'h500; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || fault !== 1'b1 || mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout.sticky: got rdy=%b f=%b v=%b r=%b expected 0 1 0 0", req_ready, fault, mem_valid, rsp_valid);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("[TB] FAIL timeout.clear: got %b expected 0", fault); end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL timeout.ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_reset_mid_bus();
    obs_t o;
    int   pulses = 0;
    req_instr = 1'b0; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h300; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset.started: got %b expected 1", mem_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    checks++;
    if (mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset.abort: got v=%b r=%b expected 0 0", mem_valid, rsp_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) pulses++;
    end
    mem_ready = 1'b0;
    checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset.quiet: got pulses=%0d rdy=%b expected 0 1", pulses, req_ready);
    end
    drive_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'h0013_0513, 1, o);
    checks++;
    if (o.mi1 !== 1'b1 || o.rsp_cycle != 3 || o.rdata !== 32'h0013_0513 || o.mi !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset.fetch: got i=%b cyc=%0d d=%h i_after=%b expected i=1 cyc=3 d=00130513 i_after=0",
                         o.mi1, o.rsp_cycle, o.rdata, o.mi);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
